spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- SPI target (mode 0) that emulates a serial NOR flash for the SoC's memory-mapped SPI flash reader.
- Serves bytes from an internal preloadable byte memory, so flash-boot SoCs can run in simulation and on boards without a physical flash.
- Sits on the far end of the spi_clk/spi_cs_n/spi_mosi/spi_miso wires; a host-side load port fills the memory.

Parameters:
- ADDR_BITS, 12, byte-address width of the internal memory (DEPTH = 2**ADDR_BITS bytes).
- JEDEC_ID, 24'hEF4016, value returned by command 0x9F, MSB first.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- spi_clk  input  1  SPI serial clock from the initiator, asynchronous to clk.
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  serial data in.
- spi_miso  output  1  serial data out.
- spi_miso_oe  output  1  high while the responder drives spi_miso.
- load_we  input  1  memory preload write strobe.
- load_addr  input  ADDR_BITS  preload byte address.
- load_data  input  8  preload byte.
- busy  output  1  high while a transaction is selected.
- bad_cmd  output  1  one-clk pulse when an unsupported opcode is received.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: spi_miso=0, spi_miso_oe=0, busy=0, bad_cmd=0, state=IDLE. Memory contents are not cleared.
- Input synchronisation:
  - spi_clk, spi_cs_n and spi_mosi each pass through a 2-FF synchroniser.
  - Edge detect on the synchronised spi_clk gives rise and fall pulses.
  - Requirement: spi_clk high and low times must each be at least 4 clk periods.
- SPI timing (mode 0, MSB first):
  - MOSI is sampled on the spi_clk rising edge.
  - spi_miso updates no later than 3 clk after the synchronised spi_clk falling edge.
- States: IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
- IDLE: on synchronised spi_cs_n falling edge -> CMD; busy=1; bit counter cleared.
- CMD: shift in 8 bits, then decode:
  - 0x03 -> ADDR (normal read).
  - 0x0B -> ADDR, followed by DUMMY (fast read).
  - 0x9F -> ID.
  - 0xAB, 0xFF -> IGNORE, with no bad_cmd.
  - Any other opcode -> IGNORE and pulse bad_cmd.
- ADDR:
  - Shift in 24 address bits; the effective address is addr[ADDR_BITS-1:0] (upper bits ignored).
  - After bit 24, read the memory byte into the shift register.
  - For 0x03 -> DATA, with spi_miso_oe=1 and the byte's bit 7 driven after the falling edge following the last address bit.
  - For 0x0B -> DUMMY.
- DUMMY: 8 clocks ignored, spi_miso_oe=0. Then -> DATA, with bit 7 driven after the 8th dummy falling edge.
- DATA:
  - Shift the byte out, one bit per falling edge.
  - After the 8th bit, increment the address modulo DEPTH and load the next byte.
  - The next byte's bit 7 must be valid before the next rising edge. Prefetch the next byte at bit 4 to meet this.
  - Reads continue indefinitely.
- ID: shift out JEDEC_ID (24 bits), then drive 0 while still selected.
- IGNORE: spi_miso_oe=0 and all clocks discarded until deselect.
- Deselect: synchronised spi_cs_n rising edge in any state -> IDLE the same cycle.
  - spi_miso_oe=0, busy=0.
  - Any partial byte is discarded and the address is not retained.
- Memory: single-port write from the load port, synchronous read for SPI.
  - A load_we write and an SPI fetch to the same address in the same clk return the old byte.
  - Loads are allowed at any time.
- Reset mid-transaction: immediate return to the reset state. A new transaction begins only at the next spi_cs_n falling edge; clocks already under way with spi_cs_n low are ignored.
- spi_clk edges while spi_cs_n is high are ignored.

Test Plan:
- Preload bytes 0x10..0x13 = A1,B2,C3,D4; send 03 00 00 10 then 32 clocks -> MISO A1 B2 C3 D4; spi_miso_oe=1 only during the data bits.
- Same preload; send 0B 00 00 10, 8 dummy clocks, then 16 clocks -> C3 is not reached; output A1 B2 with no dummy leakage.
- Send 9F then 24 clocks -> EF 40 16; further clocks -> 00.
- Preload 0xFFF=5A, 0x000=7E; send 03 00 0F FF, 16 clocks -> 5A 7E (wrap at DEPTH).
- Send 55 -> bad_cmd single-clk pulse, spi_miso_oe stays 0; deselect after 3 bits of a data byte, then a new 03 00 00 10 read -> A1 (no stale state).
- Assert rst during the address phase with spi_cs_n low -> all outputs 0 immediately; after rst release, clocks are ignored until a fresh spi_cs_n falling edge; the next read then returns the correct data.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a serial NOR flash (read 0x03, fast read 0x0B, JEDEC ID 0x9F)
// served from an internal byte memory that the host preloads through the load port.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_clk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic                 load_we,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic                 busy,
    output logic                 bad_cmd
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StId, StIgnore} state_e;

    state_e               r_state, w_state_next;
    logic [1:0]           r_sclk_ff, r_cs_ff, r_mosi_ff;
    logic                 r_sclk_d1, r_cs_d1;
    logic                 w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
    logic [4:0]           r_bit_cnt;
    logic [6:0]           r_cmd_sr;
    logic [7:0]           w_cmd_byte;
    logic                 w_cmd_done, w_cmd_known;
    logic                 r_fast;
    logic [ADDR_BITS-1:0] r_addr;
    logic [23:0]          r_sout;
    logic [7:0]           r_rd_data;
    logic [7:0]           r_mem [DEPTH];
    logic                 r_miso, r_oe, r_bad_cmd;

    // cs chain resets to "selected" so a transaction already under way at reset release
    // produces no falling edge and is ignored until a fresh select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_ff <= 2'b00;
            r_sclk_d1 <= 1'b0;
            r_cs_ff   <= 2'b00;
            r_cs_d1   <= 1'b0;
            r_mosi_ff <= 2'b00;
        end else begin
            r_sclk_ff <= {r_sclk_ff[0], spi_clk};
            r_sclk_d1 <= r_sclk_ff[1];
            r_cs_ff   <= {r_cs_ff[0], spi_cs_n};
            r_cs_d1   <= r_cs_ff[1];
            r_mosi_ff <= {r_mosi_ff[0], spi_mosi};
        end
    end

    always_comb begin
        w_sclk_rise = r_sclk_ff[1] & ~r_sclk_d1;
        w_sclk_fall = ~r_sclk_ff[1] & r_sclk_d1;
        w_cs_rise   = r_cs_ff[1] & ~r_cs_d1;
        w_cs_fall   = ~r_cs_ff[1] & r_cs_d1;
        w_mosi      = r_mosi_ff[1];
        w_cmd_byte  = {r_cmd_sr, w_mosi};
        w_cmd_done  = (r_state == StCmd) && w_sclk_rise && (r_bit_cnt == 5'd7);
        w_cmd_known = (w_cmd_byte == 8'h03) || (w_cmd_byte == 8'h0B) || (w_cmd_byte == 8'h9F)
                   || (w_cmd_byte == 8'hAB) || (w_cmd_byte == 8'hFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle:  if (w_cs_fall) w_state_next = StCmd;
                StCmd: begin
                    if (w_cmd_done) begin
                        case (w_cmd_byte)
                            8'h03, 8'h0B: w_state_next = StAddr;
                            8'h9F:        w_state_next = StId;
                            default:      w_state_next = StIgnore;
                        endcase
                    end
                end
                StAddr: begin
                    if (w_sclk_rise && r_bit_cnt == 5'd23) w_state_next = r_fast ? StDummy : StData;
                end
                StDummy: if (w_sclk_rise && r_bit_cnt == 5'd7) w_state_next = StData;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        busy        = (r_state != StIdle);
        spi_miso    = r_miso;
        spi_miso_oe = r_oe;
        bad_cmd     = r_bad_cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_cmd_sr  <= '0;
            r_fast    <= 1'b0;
            r_addr    <= '0;
            r_sout    <= '0;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_bad_cmd <= 1'b0;
        end else begin
            r_bad_cmd <= 1'b0;
            if (w_cs_rise) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_oe      <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_bit_cnt <= '0;
                        r_miso    <= 1'b0;
                        r_oe      <= 1'b0;
                    end
                    StCmd: begin
                        if (w_sclk_rise) begin
                            r_cmd_sr  <= w_cmd_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                r_fast    <= (w_cmd_byte == 8'h0B);
                                r_sout    <= JEDEC_ID;
                                r_bad_cmd <= ~w_cmd_known;
                            end
                        end
                    end
                    StAddr: begin
                        if (w_sclk_rise) begin
                            r_addr    <= {r_addr[ADDR_BITS-2:0], w_mosi};
                            r_bit_cnt <= (r_bit_cnt == 5'd23) ? 5'd0 : r_bit_cnt + 5'd1;
                        end
                    end
                    StDummy: begin
                        if (w_sclk_rise) r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                    end
                    StData: begin
                        // r_rd_data continuously follows r_addr; bumping the address mid-byte
                        // leaves several spi_clk periods for the next byte to settle.
                        if (w_sclk_fall) begin
                            r_oe <= 1'b1;
                            if (r_bit_cnt == 5'd0) begin
                                r_miso <= r_rd_data[7];
                                r_sout <= {r_rd_data[6:0], 17'd0};
                            end else begin
                                r_miso <= r_sout[23];
                                r_sout <= {r_sout[22:0], 1'b0};
                            end
                            if (r_bit_cnt == 5'd4) r_addr <= r_addr + ADDR_BITS'(1);
                            r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                        end
                    end
                    StId: begin
                        // Zeros shift in behind the ID, so MISO reads 0 once it is exhausted.
                        if (w_sclk_fall) begin
                            r_oe   <= 1'b1;
                            r_miso <= r_sout[23];
                            r_sout <= {r_sout[22:0], 1'b0};
                        end
                    end
                    default: begin
                        r_oe   <= 1'b0;
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read-before-write: a simultaneous load to the fetched address returns the old byte.
    always_ff @(posedge clk) begin
        if (load_we) r_mem[load_addr] <= load_data;
        r_rd_data <= r_mem[r_addr];
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: SPI master tasks push expected MISO bytes from a
// flat memory model; an independent monitor assembles bytes while spi_miso_oe is high.
module tb_spi_flash_responder;
    localparam int unsigned ADDR_BITS = 12;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam int          HALF      = 60;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 spi_clk = 1'b0;
    logic                 spi_cs_n = 1'b1;
    logic                 spi_mosi = 1'b0;
    logic                 spi_miso, spi_miso_oe;
    logic                 load_we = 1'b0;
    logic [ADDR_BITS-1:0] load_addr = '0;
    logic [7:0]           load_data = '0;
    logic                 busy, bad_cmd;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         bad_cnt  = 0;
    int         mon_bits = 0;
    logic [7:0] mon_byte = '0;

    spi_flash_responder #(.ADDR_BITS(ADDR_BITS), .JEDEC_ID(24'hEF4016)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy),
        .bad_cmd    (bad_cmd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Monitor: MISO is meaningful only while the DUT enables its driver.
    always @(posedge spi_clk) begin
        if (!spi_cs_n && spi_miso_oe) begin
            mon_byte = {mon_byte[6:0], spi_miso};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_miso_byte: got %02h, expected no output", mon_byte);
                end else begin
                    check("miso_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    always @(posedge spi_cs_n) mon_bits = 0;

    always @(negedge clk) if (bad_cmd) bad_cnt++;

    task automatic load_byte(input int a, input logic [7:0] d);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = ADDR_BITS'(a);
        load_data = d;
        model_mem[a % DEPTH] = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        #HALF spi_clk = 1'b1;
        #HALF spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic spi_start();
        spi_cs_n = 1'b0;
        #HALF;
        check("busy_selected", {31'd0, busy}, 32'd1);
    endtask

    task automatic spi_end();
        #HALF spi_cs_n = 1'b1;
        #(3 * HALF);
        check("busy_deselected", {31'd0, busy}, 32'd0);
        check("oe_deselected", {31'd0, spi_miso_oe}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        int base;
        base = int'(addr[ADDR_BITS-1:0]);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(model_mem[(base + i) % DEPTH]);
        spi_start();
        spi_byte(cmd);
        spi_byte(addr[23:16]);
        spi_byte(addr[15:8]);
        spi_byte(addr[7:0]);
        if (cmd == 8'h0B) repeat (8) spi_bit(1'($urandom));
        repeat (nbytes * 8) spi_bit(1'($urandom));
        spi_end();
    endtask

    task automatic do_id(input int nbytes);
        logic [23:0] jid;
        jid = 24'hEF4016;
        for (int i = 0; i < nbytes; i++) begin
            if (i < 3) exp_q.push_back(8'((jid >> (8 * (2 - i))) & 24'hFF));
            else exp_q.push_back(8'h00);
        end
        spi_start();
        spi_byte(8'h9F);
        repeat (nbytes * 8) spi_bit(1'($urandom));
        spi_end();
    endtask

    task automatic do_ignore(input logic [7:0] cmd, input int nclk, input int exp_bad);
        int b0;
        b0 = bad_cnt;
        spi_start();
        spi_byte(cmd);
        repeat (nclk) spi_bit(1'($urandom));
        spi_end();
        check("bad_cmd_pulses", bad_cnt - b0, exp_bad);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  c;
        logic [23:0] a;
        int          r;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bad_cmd", {31'd0, bad_cmd}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            load_we      = 1'b1;
            load_addr    = ADDR_BITS'(i);
            load_data    = 8'($urandom);
            model_mem[i] = load_data;
        end
        @(negedge clk) load_we = 1'b0;

        load_byte(16'h010, 8'hA1);
        load_byte(16'h011, 8'hB2);
        load_byte(16'h012, 8'hC3);
        load_byte(16'h013, 8'hD4);
        load_byte(16'hFFF, 8'h5A);
        load_byte(16'h000, 8'h7E);

        do_read(8'h03, 24'h000010, 4);
        do_read(8'h0B, 24'h000010, 2);
        do_id(5);
        do_read(8'h03, 24'h000FFF, 2);
        do_ignore(8'h55, 16, 1);
        do_ignore(8'hAB, 8, 0);
        do_ignore(8'hFF, 8, 0);

        // Deselect three bits into the first data byte; nothing may survive into the next read.
        spi_start();
        spi_byte(8'h03);
        spi_byte(8'h00);
        spi_byte(8'h00);
        spi_byte(8'h10);
        repeat (3) spi_bit(1'b0);
        spi_end();
        do_read(8'h03, 24'h000010, 1);

        // Reset in the middle of the address phase while still selected.
        spi_start();
        spi_byte(8'h03);
        spi_byte(8'h00);
        repeat (4) spi_bit(1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("midrst_miso", {31'd0, spi_miso}, 32'd0);
        check("midrst_bad_cmd", {31'd0, bad_cmd}, 32'd0);
        #40 rst = 1'b0;
        repeat (4) spi_bit(1'b0);
        spi_byte(8'h10);
        repeat (16) spi_bit(1'($urandom));
        check("postrst_busy", {31'd0, busy}, 32'd0);
        spi_end();
        do_read(8'h03, 24'h000010, 2);

        for (int t = 0; t < 14; t++) begin
            repeat ($urandom_range(0, 3)) load_byte(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            r = $urandom_range(0, 9);
            a = 24'($urandom);
            if (r < 7) begin
                do_read(($urandom_range(0, 1) == 0) ? 8'h03 : 8'h0B, a, $urandom_range(1, 4));
            end else if (r == 7) begin
                do_id($urandom_range(1, 5));
            end else begin
                do c = 8'($urandom);
                while (c == 8'h03 || c == 8'h0B || c == 8'h9F || c == 8'hAB || c == 8'hFF);
                do_ignore(c, $urandom_range(0, 16), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
